// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing controller: steps the shared ALU and unified memory through fetch/decode/execute/mem/writeback.
// Optional jump support is compiled in when MULTICYCLE_CTRL_JUMP_EN is defined; otherwise op 000010 decodes as illegal.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        IorD,
    output logic        mem_write,
    output logic        IR_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        ALU_srcA,
    output logic [1:0]  ALU_srcB,
    output logic [2:0]  ALU_control,
    output logic [1:0]  PC_src,
    output logic        PC_en,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        pc_write;
    logic        branch;
    logic        retire;
    logic        funct_ok;
    logic [2:0]  funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        IorD        = 1'b0;
        mem_write   = 1'b0;
        IR_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        ALU_srcA    = 1'b0;
        ALU_srcB    = 2'b00;
        ALU_control = ALU_ADD;
        PC_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALU_srcB = 2'b01;
                IR_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALU_srcB = 2'b11;
                case (op)
                    6'b000000: begin
                        if (funct_ok) begin
                            state_d = S_EXECUTE;
                        end else begin
                            state_d = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEXEC;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    6'b000010:            state_d = S_JUMP;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
                // Only lw and sw reach here, so sw is the only store opcode to test for.
                state_d  = (op == 6'b101011) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ALU_srcA    = 1'b1;
                ALU_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALU_srcA    = 1'b1;
                ALU_control = ALU_SUB;
                PC_src      = 2'b01;
                branch      = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                PC_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        PC_en = pc_write | (branch & zero);

        // Reset must squash any write the current state would issue, including a stalled store.
        if (rst) begin
            IorD        = 1'b0;
            mem_write   = 1'b0;
            IR_write    = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            ALU_srcA    = 1'b0;
            ALU_srcB    = 2'b00;
            ALU_control = ALU_ADD;
            PC_src      = 2'b00;
            PC_en       = 1'b0;
            illegal     = 1'b0;
            retire      = 1'b0;
        end

        instr_count_d = instr_count_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle outputs are queued as stimulus is driven
// and compared at the following falling edge. Jump expectations follow MULTICYCLE_CTRL_JUMP_EN.
module tb_multicycle_controller;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                           MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                           BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        IorD, mem_write, IR_write, reg_write, reg_dst, mem_to_reg, ALU_srcA;
    logic [1:0]  ALU_srcB, PC_src;
    logic [2:0]  ALU_control;
    logic        PC_en, illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] cnt;
        int          idx;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_idx  = 0;
    logic [31:0] exp_count = 32'd0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .mem_write(mem_write), .IR_write(IR_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB),
        .ALU_control(ALU_control), .PC_src(PC_src), .PC_en(PC_en), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packing: {IorD, mem_write, IR_write, reg_write, reg_dst, mem_to_reg, srcA, srcB, alu, pc_src, pc_en, illegal}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                             input logic ill, input logic r, input logic [5:0] f);
        logic       iord, mw, irw, rw, rd, m2r, sa, pe, il;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {iord, mw, irw, rw, rd, m2r, sa, pe, il} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        if (!r) begin
            case (st)
                FETCH:    begin sb = 2'b01; irw = mr; pe = mr; end
                DECODE:   begin sb = 2'b11; il = ill; end
                MEMADR:   begin sa = 1'b1; sb = 2'b10; end
                MEMREAD:  iord = 1'b1;
                MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
                MEMWRITE: begin iord = 1'b1; mw = 1'b1; end
                EXECUTE: begin
                    sa = 1'b1;
                    case (f)
                        6'b100010: ac = 3'b110;
                        6'b100100: ac = 3'b000;
                        6'b100101: ac = 3'b001;
                        6'b101010: ac = 3'b111;
                        default:   ac = 3'b010;
                    endcase
                end
                ALUWB:    begin rw = 1'b1; rd = 1'b1; end
                BRANCH:   begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
                ADDIEXEC: begin sa = 1'b1; sb = 2'b10; end
                ADDIWB:   rw = 1'b1;
                JUMP:     begin ps = 2'b10; pe = 1'b1; end
                default:  ;
            endcase
        end
        return {iord, mw, irw, rw, rd, m2r, sa, sb, ac, ps, pe, il};
    endfunction

    // Drive one cycle (called just after a rising edge) and queue what the DUT must show in it.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic ill,
                       input logic fin, input logic r);
        exp_t e;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        e.st   = st;
        e.ctrl = exp_ctrl(st, mr, z, ill, r, funct);
        e.cnt  = exp_count;
        e.idx  = cyc_idx;
        sb_q.push_back(e);
        cyc_idx++;
        @(posedge clk);
        #1;
        if (r) exp_count = 32'd0;
        else if (fin) exp_count = exp_count + 32'd1;
    endtask

    task automatic issue(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int fstall, input int mstall);
        bit legal;
        op    = o;
        funct = f;
        $display("issue %-6s op=%b funct=%b zero=%b fetch_stall=%0d mem_stall=%0d count_before=%0d",
                 name, o, f, z, fstall, mstall, exp_count);
        repeat (fstall) cyc(FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        case (o)
            6'b000000: legal = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                               (f == 6'b100101) || (f == 6'b101010);
            6'b100011, 6'b101011, 6'b000100, 6'b001000: legal = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            6'b000010: legal = 1'b1;
`endif
            default:   legal = 1'b0;
        endcase
        if (!legal) begin
            cyc(DECODE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            return;
        end
        cyc(DECODE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        case (o)
            6'b100011: begin
                cyc(MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                repeat (mstall) cyc(MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(MEMREAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(MEMWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            6'b101011: begin
                cyc(MEMADR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                repeat (mstall) cyc(MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(MEMWRITE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            6'b000000: begin
                cyc(EXECUTE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(ALUWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            6'b000100: cyc(BRANCH, 1'b1, z, 1'b0, 1'b1, 1'b0);
            6'b001000: begin
                cyc(ADDIEXEC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(ADDIWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            default:   cyc(JUMP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        endcase
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("c%0d_state", e.idx), {28'd0, state}, {28'd0, e.st});
            check($sformatf("c%0d_ctrl", e.idx),
                  {16'd0, IorD, mem_write, IR_write, reg_write, reg_dst, mem_to_reg, ALU_srcA,
                   ALU_srcB, ALU_control, PC_src, PC_en, illegal}, {16'd0, e.ctrl});
            check($sformatf("c%0d_count", e.idx), instr_count, e.cnt);
        end
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = 6'd0; funct = 6'd0;
        @(posedge clk);
        #1;
        $display("reset hold 3 cycles");
        repeat (3) cyc(FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        issue("lw",    6'b100011, 6'd0,      1'b0, 0, 0);
        issue("sw",    6'b101011, 6'd0,      1'b0, 0, 2);
        issue("beq_t", 6'b000100, 6'd0,      1'b1, 0, 0);
        issue("beq_n", 6'b000100, 6'd0,      1'b0, 0, 0);
        issue("sub",   6'b000000, 6'b100010, 1'b0, 0, 0);
        issue("add",   6'b000000, 6'b100000, 1'b0, 0, 0);
        issue("and",   6'b000000, 6'b100100, 1'b0, 0, 0);
        issue("or",    6'b000000, 6'b100101, 1'b0, 0, 0);
        issue("slt",   6'b000000, 6'b101010, 1'b0, 0, 0);
        issue("badfn", 6'b000000, 6'b000111, 1'b0, 0, 0);
        issue("addi",  6'b001000, 6'd0,      1'b0, 0, 0);
        issue("j",     6'b000010, 6'd0,      1'b0, 0, 0);
        issue("badop", 6'b111111, 6'd0,      1'b0, 0, 0);
        issue("lw_st", 6'b100011, 6'd0,      1'b0, 1, 2);

        // Store stalled in MEMWRITE is abandoned by reset; no write and the count clears.
        $display("issue sw_rst op=101011 reset during MEMWRITE stall");
        op = 6'b101011; funct = 6'd0;
        cyc(FETCH,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(DECODE,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMADR,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(MEMWRITE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(FETCH,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue("addi",  6'b001000, 6'd0,      1'b0, 0, 0);
        issue("sw",    6'b101011, 6'd0,      1'b0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        check("drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle combinational control path with a state machine that steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback. Each step of an instruction gets one or more clock cycles. It sits beside the datapath: it takes the registered instruction fields and the ALU zero flag, and drives every datapath mux select and write enable.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU result == 0
- mem_ready  in  1  unified memory has completed the current access this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALU_out
- mem_write  out  1  memory write enable
- IR_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALU_out, 1 = memory data register
- ALU_srcA  out  1  0 = PC, 1 = register A
- ALU_srcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALU_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PC_src  out  2  00 = ALU result, 01 = ALU_out (branch target), 10 = jump target
- PC_en  out  1  PC load; equals PC_write | (branch & zero)
- illegal  out  1  one-cycle pulse when an unsupported op or funct is decoded
- state  out  4  current state, for debug
- instr_count  out  32  count of retired instructions

## Operation
- State encoding:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMREAD
  - 4 MEMWB
  - 5 MEMWRITE
  - 6 EXECUTE
  - 7 ALUWB
  - 8 BRANCH
  - 9 ADDIEXEC
  - 10 ADDIWB
  - 11 JUMP
  - Codes 12–15 are unreachable and return to FETCH.
- Default output values: every enable is 0, all selects are 0, ALU_control = 010.
- FETCH:
  - Drives IorD = 0, ALU_srcA = 0, ALU_srcB = 01, add.
  - IR_write and PC_write are asserted only while mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; moves to DECODE when mem_ready = 1.
- DECODE:
  - Drives ALU_srcA = 0, ALU_srcB = 11, add.
  - Transitions by op:
    - 000000 (R-type) → EXECUTE
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEXEC
    - 000010 (j) → JUMP
  - Anything else → FETCH with illegal = 1.
- Legal R-type funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is detected in DECODE → FETCH with illegal = 1.
- MEMADR:
  - Drives ALU_srcA = 1, ALU_srcB = 10, add.
  - lw → MEMREAD; sw → MEMWRITE.
- MEMREAD:
  - Drives IorD = 1.
  - Waits while mem_ready = 0; moves to MEMWB when mem_ready = 1.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1; → FETCH.
- MEMWRITE:
  - Holds IorD = 1 and mem_write = 1 until mem_ready = 1, then → FETCH.
- EXECUTE: ALU_srcA = 1, ALU_srcB = 00, ALU_control decoded from funct; → ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; → FETCH.
- BRANCH:
  - Drives ALU_srcA = 1, ALU_srcB = 00, sub, PC_src = 01, branch = 1.
  - PC_en = zero; → FETCH.
- ADDIEXEC: ALU_srcA = 1, ALU_srcB = 10, add; → ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0; → FETCH.
- JUMP: PC_src = 10, PC_write = 1; → FETCH.
- instr_count:
  - Increments by 1 on the final cycle of each legal instruction, i.e. the cycle that transitions back to FETCH without illegal.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not increment on illegal.

## Timing
- Outputs are Moore on state, except these Mealy terms:
  - IR_write and PC_write in FETCH, gated by mem_ready.
  - PC_en in BRANCH, gated by zero.
  - illegal in DECODE.
- Cycles per instruction with mem_ready held at 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready = 0 adds one cycle.
- Reset:
  - While rst = 1, state ← FETCH and instr_count ← 0 at each edge.
  - All enables (IR_write, PC_en, reg_write, mem_write) and illegal are forced to 0 combinationally during rst; selects take their default values.
- Reset asserted mid-instruction (including during a MEMWRITE stall) abandons the instruction. No partial writeback occurs after the reset edge.
- First fetch begins in the first cycle after rst deasserts.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN:
  - Defined: op 000010 decodes to JUMP as above.
  - Undefined: the JUMP state is not compiled, op 000010 is illegal (DECODE → FETCH, illegal = 1), and PC_src never takes 10.

## Test plan
- Reset: hold rst for 3 cycles with mem_ready = 1 → state = 0, instr_count = 0, all enables 0; first cycle after release has IR_write = 1 and PC_en = 1.
- lw (op 100011), mem_ready = 1 → states 0,1,2,3,4; reg_write = 1 with mem_to_reg = 1 only in state 4; instr_count = 1 after 5 cycles.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_write high for 3 consecutive cycles; 6 cycles total; reg_write never asserted.
- beq (op 000100):
  - zero = 1 → PC_en = 1 and PC_src = 01 in state 8.
  - zero = 0 → PC_en = 0; 3 cycles total in both cases.
- R-type with funct 100010 → ALU_control = 110 in EXECUTE. With funct 000111 → illegal pulses 1 cycle in DECODE, next state FETCH, instr_count unchanged.
- Configuration check: j (op 000010) with MULTICYCLE_CTRL_JUMP_EN defined → PC_src = 10 and PC_en = 1 in state 11. Without the macro → illegal = 1 in DECODE.
